addsub_multicycle: RTL and testbench

- Parametrised, multi-cycle two's-complement adder/subtractor; successor to the fixed 8-bit combinational subtractor.
- Processes a WIDTH-bit operation SLICE bits per clock, LSB slice first, through one SLICE-bit ripple-carry stage and a registered carry.
- Start/ready/done handshake.
- Used by datapath labs needing wide arithmetic with bounded combinational depth.

---
 rtl/addsub_multicycle.sv | 161 ++++++++++++++++
 tb/tb_addsub_multicycle.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_multicycle.sv
// ============================================================================
//  Module   : addsub_multicycle
//  Purpose  : Multi-cycle two's-complement adder/subtractor, SLICE bits per
//             clock through a single ripple stage with a registered carry.
//             Optional signed saturation when ADDSUB_SAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_multicycle #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] C_LAST = KW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic               sub_q,    sub_d;
    logic               c_q,      c_d;
    logic [WIDTH-1:0]   part_q,   part_d;
    logic [KW-1:0]      k_q,      k_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;

    int                 w_idx;
    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE:0]     w_sum;
    logic [WIDTH-1:0]   w_full;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_res;

    // One ripple slice; w_full is the assembled sum as it will look after this edge.
    always_comb begin
        w_idx  = int'(k_q) * SLICE;
        w_a_sl = a_q[w_idx +: SLICE];
        w_b_sl = b_q[w_idx +: SLICE];
        w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, c_q};
        w_full = part_q;
        w_full[w_idx +: SLICE] = w_sum[SLICE-1:0];
        w_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_full[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        if (w_ovf) begin
            w_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_res = w_full;
        end
`else
        w_res  = w_full;
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        c_d      = c_q;
        part_d   = part_q;
        k_d      = k_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    sub_d   = sub;
                    // Subtraction as A + ~B + (1 - bin): the borrow-in inverts.
                    c_d     = carry_in ^ sub;
                    part_d  = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                part_d = w_full;
                c_d    = w_sum[SLICE];
                k_d    = k_q + 1'b1;
                if (k_q == C_LAST) begin
                    result_d = w_res;
                    cout_d   = w_sum[SLICE] ^ sub_q;
                    ovf_d    = w_ovf;
                    zero_d   = (w_res == '0);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            part_q   <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            part_q   <= part_d;
            k_q      <= k_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_multicycle.sv
// ============================================================================
//  Module   : tb_addsub_multicycle
//  Purpose  : Scoreboard bench for addsub_multicycle (WIDTH=32, SLICE=8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_addsub_multicycle;

    localparam int W = 32;
    localparam int N = 4;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         ready, done, carry_out, overflow, zero;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] last_res = '0;
    logic         last_co = 1'b0, last_ov = 1'b0, last_z = 1'b0;

    addsub_multicycle #(.WIDTH(W), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .ready(ready), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops on every done, otherwise checks that outputs hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("carry_out", 32'(carry_out), 32'(e.co));
                    chk("overflow", 32'(overflow), 32'(e.ov));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ready_in_done", 32'(ready), 32'd1);
                    last_res = e.res;
                    last_co  = e.co;
                    last_ov  = e.ov;
                    last_z   = e.z;
                end
            end else begin
                chk("hold_result", result, last_res);
                chk("hold_flags", {29'd0, carry_out, overflow, zero},
                    {29'd0, last_co, last_ov, last_z});
            end
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic ci, input logic [W-1:0] r_wrap, input logic [W-1:0] r_sat,
                         input logic co, input logic ov, input logic z, input bit track);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'(ready), 32'd1);
        start    = 1'b1;
        sub      = s;
        a        = aa;
        b        = bb;
        carry_in = ci;
        @(posedge clk);
        #1;
        if (track) begin
            e.res = SAT ? r_sat : r_wrap;
            e.co  = co;
            e.ov  = ov;
            e.z   = z;
            e.cyc = cyc + N;
            sb.push_back(e);
        end
        // Scramble inputs after accept; they must not affect the operation.
        start    = 1'b0;
        sub      = ~s;
        a        = $urandom;
        b        = $urandom;
        carry_in = ~ci;
    endtask

    initial begin
        int guard;
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;

        issue(1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 32'd5, 32'd7, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 32'd7, 32'd5, 1'b1, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1);

        // start pulsed mid-operation must be ignored
        issue(1'b0, 32'h000F0000, 32'h00F00000, 1'b0, 32'h00FF0000, 32'h00FF0000, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a     = 32'h11111111;
        b     = 32'h22222222;
        @(negedge clk);
        start = 1'b0;

        // Abort at slice 2: operation started, reset lands mid-RUN
        issue(1'b0, 32'h01010101, 32'h02020202, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #3;
        rst_n    = 1'b0;
        last_res = '0;
        last_co  = 1'b0;
        last_ov  = 1'b0;
        last_z   = 1'b0;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_abort_ready", 32'(ready), 32'd1);

        issue(1'b1, 32'h00000100, 32'h00000001, 1'b1, 32'h000000FE, 32'h000000FE, 1'b0, 1'b0, 1'b0, 1'b1);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
